// File: rtl/conv_sched_pkg.sv
// Shared types and default widths for the convolution loop-nest scheduler.
package conv_sched_pkg;

    localparam int W_DEF  = 4;
    localparam int AW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Config snapshot taken at start; widths follow the package defaults.
    typedef struct packed {
        logic [W_DEF-1:0]  c_fin;
        logic [W_DEF-1:0]  y_fin;
        logic [W_DEF-1:0]  x_fin;
        logic [AW_DEF-1:0] w_base;
        logic [AW_DEF-1:0] i_base;
        logic [AW_DEF-1:0] ystride;
        logic [AW_DEF-1:0] cstride;
    } cfg_t;

endpackage

// File: rtl/loop_ctr.sv
// One loop level: counts 0..fin, wrapping to 0 when advanced at fin.
module loop_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] fin,
    output logic [W-1:0] idx,
    output logic         at_fin
);

    assign at_fin = (idx == fin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (inc) begin
            idx <= at_fin ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/conv_loop_sched.sv
// Runtime-configurable (c, y, x) loop-nest scheduler issuing weight/input
// address pairs over a valid/ready stream; input address built with adds only.
module conv_loop_sched
    import conv_sched_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  cfg_c_fin,
    input  logic [W-1:0]  cfg_y_fin,
    input  logic [W-1:0]  cfg_x_fin,
    input  logic [AW-1:0] cfg_w_base,
    input  logic [AW-1:0] cfg_i_base,
    input  logic [AW-1:0] cfg_i_ystride,
    input  logic [AW-1:0] cfg_i_cstride,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_wa,
    output logic [AW-1:0] out_ia,
    output logic          out_first,
    output logic          out_last
);

    state_t        state;
    state_t        state_nxt;
    cfg_t          cfg;
    logic [AW-1:0] wa;
    logic [AW-1:0] ia;
    logic [AW-1:0] row;
    logic [AW-1:0] chan;
    logic [W-1:0]  x_idx;
    logic [W-1:0]  y_idx;
    logic [W-1:0]  c_idx;
    logic          x_at_fin;
    logic          y_at_fin;
    logic          c_at_fin;
    logic          load;
    logic          beat;
    logic          last_idx;

    // Abort outranks both a start in IDLE and an accepted beat in RUN.
    assign load     = (state == IDLE) && start && !abort;
    assign beat     = (state == RUN) && out_ready && !abort;
    assign last_idx = x_at_fin && y_at_fin && c_at_fin;

    loop_ctr #(.W(W)) u_x_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (load),
        .inc    (beat),
        .fin    (cfg.x_fin),
        .idx    (x_idx),
        .at_fin (x_at_fin)
    );

    loop_ctr #(.W(W)) u_y_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (load),
        .inc    (beat && x_at_fin),
        .fin    (cfg.y_fin),
        .idx    (y_idx),
        .at_fin (y_at_fin)
    );

    loop_ctr #(.W(W)) u_c_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (load),
        .inc    (beat && x_at_fin && y_at_fin),
        .fin    (cfg.c_fin),
        .idx    (c_idx),
        .at_fin (c_at_fin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (load) state_nxt = RUN;
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (out_ready && last_idx) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            RUN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    assign out_first = out_valid && (x_idx == '0) && (y_idx == '0) && (c_idx == '0);
    assign out_last  = out_valid && last_idx;
    assign out_wa    = wa;
    assign out_ia    = ia;

    // row/chan remember the start of the current row/channel so every wrap
    // is a single add of one stride.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg  <= '0;
            wa   <= '0;
            ia   <= '0;
            row  <= '0;
            chan <= '0;
        end else if (load) begin
            cfg.c_fin   <= cfg_c_fin;
            cfg.y_fin   <= cfg_y_fin;
            cfg.x_fin   <= cfg_x_fin;
            cfg.w_base  <= cfg_w_base;
            cfg.i_base  <= cfg_i_base;
            cfg.ystride <= cfg_i_ystride;
            cfg.cstride <= cfg_i_cstride;
            wa          <= cfg_w_base;
            ia          <= cfg_i_base;
            row         <= cfg_i_base;
            chan        <= cfg_i_base;
        end else if (beat) begin
            wa <= wa + 1'b1;
            if (!x_at_fin) begin
                ia <= ia + 1'b1;
            end else if (!y_at_fin) begin
                row <= row + cfg.ystride;
                ia  <= row + cfg.ystride;
            end else if (!c_at_fin) begin
                chan <= chan + cfg.cstride;
                row  <= chan + cfg.cstride;
                ia   <= chan + cfg.cstride;
            end
        end
    end

endmodule

// File: tb/tb_conv_loop_sched.sv
// Bench for conv_loop_sched: table of nests checked beat-by-beat against a
// nested-loop reference, plus hand-written reset/abort sequences.
module tb_conv_loop_sched;
    import conv_sched_pkg::*;

    localparam int W  = W_DEF;
    localparam int AW = AW_DEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  cfg_c_fin = '0;
    logic [W-1:0]  cfg_y_fin = '0;
    logic [W-1:0]  cfg_x_fin = '0;
    logic [AW-1:0] cfg_w_base = '0;
    logic [AW-1:0] cfg_i_base = '0;
    logic [AW-1:0] cfg_i_ystride = '0;
    logic [AW-1:0] cfg_i_cstride = '0;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic [AW-1:0] out_wa;
    logic [AW-1:0] out_ia;
    logic          out_first;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]  c_fin;
        logic [W-1:0]  y_fin;
        logic [W-1:0]  x_fin;
        logic [AW-1:0] w_base;
        logic [AW-1:0] i_base;
        logic [AW-1:0] ystride;
        logic [AW-1:0] cstride;
        int            mode;
        int            abort_at;
        int            poke_at;
        int            exp_beats;
        int            exp_dones;
        logic [AW-1:0] exp_last_wa;
        logic [AW-1:0] exp_last_ia;
    } vec_t;

    typedef struct {
        logic [AW-1:0] wa;
        logic [AW-1:0] ia;
        logic          first;
        logic          last;
    } beat_t;

    vec_t vecs[$];

    conv_loop_sched #(.W(W), .AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_c_fin     (cfg_c_fin),
        .cfg_y_fin     (cfg_y_fin),
        .cfg_x_fin     (cfg_x_fin),
        .cfg_w_base    (cfg_w_base),
        .cfg_i_base    (cfg_i_base),
        .cfg_i_ystride (cfg_i_ystride),
        .cfg_i_cstride (cfg_i_cstride),
        .busy          (busy),
        .done          (done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_wa        (out_wa),
        .out_ia        (out_ia),
        .out_first     (out_first),
        .out_last      (out_last)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int cf, input int yf, input int xf,
                                input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                                input logic [AW-1:0] ys, input logic [AW-1:0] cs,
                                input int mode, input int ab, input int pk,
                                input int eb, input int ed,
                                input logic [AW-1:0] lw, input logic [AW-1:0] li);
        vec_t v;
        v.c_fin = W'(cf);  v.y_fin = W'(yf);  v.x_fin = W'(xf);
        v.w_base = wb;     v.i_base = ib;     v.ystride = ys;  v.cstride = cs;
        v.mode = mode;     v.abort_at = ab;   v.poke_at = pk;
        v.exp_beats = eb;  v.exp_dones = ed;
        v.exp_last_wa = lw; v.exp_last_ia = li;
        return v;
    endfunction

    task automatic scramble_cfg();
        cfg_c_fin     = W'($urandom);
        cfg_y_fin     = W'($urandom);
        cfg_x_fin     = W'($urandom);
        cfg_w_base    = $urandom;
        cfg_i_base    = $urandom;
        cfg_i_ystride = $urandom;
        cfg_i_cstride = $urandom;
    endtask

    // Runs one nest; mode 0 = ready always high, 1 = toggling, 2 = random.
    task automatic apply_stimulus(input vec_t v, output int beats, output int dones,
                                  output logic [AW-1:0] last_wa, output logic [AW-1:0] last_ia);
        beat_t         exp_q[$];
        int            bi;
        int            post;
        int            budget;
        bit            rdy;
        bit            stalled;
        bit            aborted;
        bit            timed_out;
        logic [AW-1:0] pwa;
        logic [AW-1:0] pia;
        logic          pfirst;
        logic          plast;

        exp_q = {};
        bi = 0;
        for (int c = 0; c <= int'(v.c_fin); c++)
            for (int y = 0; y <= int'(v.y_fin); y++)
                for (int x = 0; x <= int'(v.x_fin); x++) begin
                    exp_q.push_back('{
                        wa:    v.w_base + AW'(bi),
                        ia:    v.i_base + AW'(c) * v.cstride + AW'(y) * v.ystride + AW'(x),
                        first: (c == 0 && y == 0 && x == 0),
                        last:  (c == int'(v.c_fin) && y == int'(v.y_fin) && x == int'(v.x_fin))});
                    bi++;
                end

        beats = 0; dones = 0; last_wa = '0; last_ia = '0;
        stalled = 0; aborted = 0; post = 0; timed_out = 1;
        pwa = '0; pia = '0; pfirst = 0; plast = 0;
        budget = 8 * exp_q.size() + 20;

        cfg_c_fin = v.c_fin;  cfg_y_fin = v.y_fin;  cfg_x_fin = v.x_fin;
        cfg_w_base = v.w_base; cfg_i_base = v.i_base;
        cfg_i_ystride = v.ystride; cfg_i_cstride = v.cstride;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("start_latency_valid", out_valid, 1);
        check_output("start_latency_busy", busy, 1);
        scramble_cfg();

        for (int cyc = 0; cyc < budget; cyc++) begin
            if (out_valid) begin
                if (stalled) begin
                    check_output("stall_hold_wa", out_wa, pwa);
                    check_output("stall_hold_ia", out_ia, pia);
                    check_output("stall_hold_first", out_first, pfirst);
                    check_output("stall_hold_last", out_last, plast);
                end
                if (beats < exp_q.size()) begin
                    check_output($sformatf("beat%0d_wa", beats), out_wa, exp_q[beats].wa);
                    check_output($sformatf("beat%0d_ia", beats), out_ia, exp_q[beats].ia);
                    check_output($sformatf("beat%0d_first", beats), out_first, exp_q[beats].first);
                    check_output($sformatf("beat%0d_last", beats), out_last, exp_q[beats].last);
                end
                check_output("busy_while_valid", busy, 1);
            end else if (stalled) begin
                check_output("stall_valid_dropped", out_valid, 1);
            end
            if (done) begin
                dones++;
                check_output("done_busy_low", busy, 0);
                check_output("done_valid_low", out_valid, 0);
            end
            if (dones > 0 || aborted) begin
                post++;
                if (post > 3) begin
                    timed_out = 0;
                    break;
                end
            end

            case (v.mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (out_valid && v.poke_at == beats) start = 1'b1;
            if (out_valid && rdy && v.abort_at == beats + 1) begin
                abort = 1'b1;
                aborted = 1;
            end else if (out_valid && rdy) begin
                last_wa = out_wa;
                last_ia = out_ia;
                beats++;
            end
            stalled = out_valid && !rdy;
            pwa = out_wa; pia = out_ia; pfirst = out_first; plast = out_last;

            @(negedge clk);
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                check_output("abort_valid_low", out_valid, 0);
                check_output("abort_busy_low", busy, 0);
                check_output("abort_no_done", done, 0);
            end
        end
        out_ready = 1'b0;
        check_output("nest_timeout", timed_out, 0);
    endtask

    initial begin
        int            beats;
        int            dones;
        logic [AW-1:0] lw;
        logic [AW-1:0] li;

        vecs.push_back(mk(2, 2, 2, 32'h0, 32'h0, 32'd10, 32'd100, 0, -1, -1, 27, 1, 32'd26, 32'd222));
        vecs.push_back(mk(2, 2, 2, 32'h0, 32'h0, 32'd10, 32'd100, 1, -1, -1, 27, 1, 32'd26, 32'd222));
        vecs.push_back(mk(2, 2, 2, 32'h0, 32'h0, 32'd10, 32'd100, 2, -1, -1, 27, 1, 32'd26, 32'd222));
        vecs.push_back(mk(0, 0, 0, 32'h40, 32'h1000, 32'd10, 32'd100, 0, -1, -1, 1, 1, 32'h40, 32'h1000));
        vecs.push_back(mk(0, 0, 3, 32'h0, 32'hFFFF_FFFE, 32'h20, 32'h400, 2, -1, -1, 4, 1, 32'd3, 32'h1));
        vecs.push_back(mk(2, 2, 2, 32'h0, 32'h0, 32'd10, 32'd100, 0, 5, -1, 4, 0, 32'd3, 32'd10));
        vecs.push_back(mk(2, 2, 2, 32'h0, 32'h0, 32'd10, 32'd100, 0, -1, -1, 27, 1, 32'd26, 32'd222));
        vecs.push_back(mk(2, 2, 2, 32'h0, 32'h0, 32'd10, 32'd100, 0, -1, 10, 27, 1, 32'd26, 32'd222));
        for (int i = 0; i < 6; i++) begin
            int            cf = $urandom_range(0, 3);
            int            yf = $urandom_range(0, 3);
            int            xf = $urandom_range(0, 3);
            logic [AW-1:0] wb = $urandom;
            logic [AW-1:0] ib = $urandom;
            logic [AW-1:0] ys = $urandom;
            logic [AW-1:0] cs = $urandom;
            int            nb = (cf + 1) * (yf + 1) * (xf + 1);
            vecs.push_back(mk(cf, yf, xf, wb, ib, ys, cs, $urandom_range(0, 2), -1, -1, nb, 1,
                              wb + AW'(nb - 1), ib + AW'(cf) * cs + AW'(yf) * ys + AW'(xf)));
        end

        repeat (3) @(negedge clk);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_valid", out_valid, 0);
        check_output("reset_first", out_first, 0);
        check_output("reset_last", out_last, 0);
        check_output("reset_wa", out_wa, 0);
        check_output("reset_ia", out_ia, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i], beats, dones, lw, li);
            check_output($sformatf("vec%0d_beats", i), beats, vecs[i].exp_beats);
            check_output($sformatf("vec%0d_dones", i), dones, vecs[i].exp_dones);
            check_output($sformatf("vec%0d_last_wa", i), lw, vecs[i].exp_last_wa);
            check_output($sformatf("vec%0d_last_ia", i), li, vecs[i].exp_last_ia);
        end

        // Asynchronous reset in the middle of a nest.
        cfg_c_fin = 4'd2; cfg_y_fin = 4'd2; cfg_x_fin = 4'd2;
        cfg_w_base = 32'h100; cfg_i_base = 32'h200;
        cfg_i_ystride = 32'd10; cfg_i_cstride = 32'd100;
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_output("midrun_wa_before_reset", out_wa, 32'h105);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_reset_valid", out_valid, 0);
        check_output("async_reset_busy", busy, 0);
        check_output("async_reset_wa", out_wa, 0);
        check_output("async_reset_ia", out_ia, 0);
        check_output("async_reset_first", out_first, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("post_reset_no_done", done, 0);
            check_output("post_reset_idle", busy, 0);
        end

        // Abort together with start in IDLE must not launch a nest.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_output("abort_start_idle_busy", busy, 0);
        check_output("abort_start_idle_valid", out_valid, 0);
        @(negedge clk);
        check_output("abort_start_idle_still", busy, 0);
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
